serial_byte_adder: RTL and testbench
====================================

Name: serial_byte_adder

Overview:
- Multi-cycle wide adder that drives the existing 8-bit ripple-carry adder (RCA_8Bit: a, b, cin -> s, c) one byte per clock.
- Captures two NBYTES-wide operands, feeds byte i to the RCA in cycle i, and registers the carry between cycles.
- Assembles the full-width sum and reports completion with a start/busy/done handshake.
- Sits directly upstream of RCA_8Bit: sequences its operands and consumes its outputs.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..16; total width W = 8*NBYTES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new addition; sampled only in IDLE
- op_a  in  W  operand A; captured on the accepted start
- op_b  in  W  operand B; captured on the accepted start
- cin  in  1  initial carry-in; captured on the accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when the result is complete
- sum  out  W  registered result; valid from done, held until the next accepted start
- cout  out  1  registered carry out of the MSB byte
- overflow  out  1  registered two's-complement overflow of the W-bit result

Behaviour:
- Timing: one clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset:
  - state=IDLE, byte index=0, carry register=0.
  - busy=0, done=0, sum=0, cout=0, overflow=0.
  - rst takes priority over every other input, including mid-RUN; a partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op_a, op_b, cin into internal registers, sets index=0, clears sum to 0 and goes to RUN.
  - start=0 stays in IDLE.
  - Outputs hold their previous values.
- RUN (busy=1):
  - RCA inputs: a = latched A byte[index], b = latched B byte[index], cin = carry register.
  - Each cycle: sum byte[index] <= RCA s; carry register <= RCA c; index <= index+1.
  - After byte NBYTES-1 is written: cout <= RCA c, overflow <= (a[7]==b[7]) && (s[7]!=a[7]) for that byte, state -> DONE.
  - start is ignored.
  - Operand ports may change freely; only the latched copies are used.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - start is ignored in DONE; back-to-back operations are spaced by at least one IDLE cycle.
- Latency: with start sampled at edge 0, RUN occupies edges 1..NBYTES and done is high in the cycle following edge NBYTES. Total NBYTES+1 cycles from start to done.
- Intermediate result: sum bytes above index are 0 during RUN; sum is meaningful only from done onward.
- Arithmetic:
  - Modulo 2^W.
  - cout is the unsigned carry out.
  - overflow is computed from the effective B byte fed to the RCA.
- Index counter width: clog2(NBYTES); it never wraps within an operation.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands on the accepted start.
  - sub=1: every B byte is bitwise inverted before the RCA, and the initial carry is forced to 1 (the cin port is ignored). Result = A - B; cout=1 means no borrow.
  - sub=0: identical to plain add.
- Not defined: no sub port; the block only adds.

Test Plan:
- NBYTES=4, A=0x00000004, B=0x00000006, cin=0, start one cycle -> busy for 4 cycles, done pulse in the 5th cycle, sum=0x0000000A, cout=0, overflow=0.
- A=0xFFFFFFFF, B=0x00000000, cin=1 -> carry ripples through all bytes; sum=0x00000000, cout=1, overflow=0.
- A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, cout=0, overflow=1.
- Start with A=0x11111111, B=0x22222222; hold start high and change operands during RUN and DONE -> exactly one done pulse; sum=0x33333333; a new operation begins only after returning to IDLE.
- Assert rst in the 2nd RUN cycle, then start A=0x000000FF, B=0x00000001 -> after reset all outputs are 0 and state is IDLE; new result sum=0x00000100, cout=0.
- With SERIAL_ADD_SUB_EN: A=5, B=7, sub=1 -> sum=0xFFFFFFFE, cout=0. A=7, B=5, sub=1 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/serial_byte_adder_if.sv
// Handshake/data bundle for serial_byte_adder.
// Carries the optional sub request when SERIAL_ADD_SUB_EN is defined.
interface serial_byte_adder_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_byte_adder.sv
// Byte-serial wide adder driving an 8-bit ripple-carry adder, one byte per clock.
// Define SERIAL_ADD_SUB_EN to add a subtract mode (A - B via inverted B and carry-in 1).
module RCA_8Bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c
);
    logic [8:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]         = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign c = w_carry[8];
endmodule

module serial_byte_adder #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_byte_adder_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;
    logic          r_sub;
    logic          w_sub_req;

    logic [7:0]    w_a;
    logic [7:0]    w_b;
    logic [7:0]    w_s;
    logic          w_c;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub_req = bus.sub;
`else
    assign w_sub_req = 1'b0;
`endif

    // The effective B byte (inverted when subtracting) also feeds the overflow check.
    assign w_a = r_a[8*r_idx +: 8];
    assign w_b = r_sub ? ~r_b[8*r_idx +: 8] : r_b[8*r_idx +: 8];

    RCA_8Bit u_rca (
        .a   (w_a),
        .b   (w_b),
        .cin (r_carry),
        .s   (w_s),
        .c   (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_sub   <= w_sub_req;
                        r_carry <= w_sub_req ? 1'b1 : bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[8*r_idx +: 8] <= w_s;
                    r_carry             <= w_c;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_c;
                        r_ovf   <= (w_a[7] == w_b[7]) && (w_s[7] != w_a[7]);
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_serial_byte_adder.sv
// Directed self-checking bench for serial_byte_adder (NBYTES=4).
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_byte_adder;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_byte_adder_if #(.NBYTES(NBYTES)) bus ();

    serial_byte_adder #(.NBYTES(NBYTES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses start for one cycle, then watches negedges until done (bounded).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, output int busyCnt, output int doneAt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = s;
`else
        if (s) $display("[TB] sub requested but feature not built");
`endif
        @(negedge clk);
        bus.start = 1'b0;
        busyCnt   = 0;
        doneAt    = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneAt = n;
                break;
            end
        end
        if (doneAt == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: done not seen within 20 cycles, required by cycle %0d", NBYTES + 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== {2'b00, {W{1'b0}}, 2'b00}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        int busyCnt, doneAt;
        do_op(32'h0000_0004, 32'h0000_0006, 1'b0, 1'b0, busyCnt, doneAt);
        checks++;
        if (busyCnt !== NBYTES) begin
            errors++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, required %0d", busyCnt, NBYTES);
        end
        checks++;
        if (doneAt !== NBYTES + 1) begin
            errors++;
            $display("[TB] FAIL basic_done_latency: got %0d, required %0d", doneAt, NBYTES + 1);
        end
        checks++;
        if ({bus.sum, bus.cout, bus.overflow} !== {32'h0000_000A, 2'b00}) begin
            errors++;
            $display("[TB] FAIL basic_result: sum=%h cout=%b ovf=%b, required 0000000a 0 0",
                     bus.sum, bus.cout, bus.overflow);
        end
        @(negedge clk);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.sum !== 32'h0000_000A) begin
            errors++;
            $display("[TB] FAIL basic_done_pulse: done=%b busy=%b sum=%h, required 0 0 0000000a",
                     bus.done, bus.busy, bus.sum);
        end
    endtask

    task automatic test_carry_ripple();
        int busyCnt, doneAt;
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, busyCnt, doneAt);
        checks++;
        if ({bus.sum, bus.cout, bus.overflow} !== {32'h0000_0000, 2'b10}) begin
            errors++;
            $display("[TB] FAIL ripple_result: sum=%h cout=%b ovf=%b, required 00000000 1 0",
                     bus.sum, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_overflow();
        int busyCnt, doneAt;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, busyCnt, doneAt);
        checks++;
        if ({bus.sum, bus.cout, bus.overflow} !== {32'h8000_0000, 2'b01}) begin
            errors++;
            $display("[TB] FAIL overflow_result: sum=%h cout=%b ovf=%b, required 80000000 0 1",
                     bus.sum, bus.cout, bus.overflow);
        end
    endtask

    task automatic test_start_held();
        int doneCnt;
        doneCnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'h1111_1111;
        bus.op_b  = 32'h2222_2222;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        for (int n = 1; n <= NBYTES + 3; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++;
                if (bus.sum !== 32'h0) begin
                    errors++;
                    $display("[TB] FAIL held_sum_cleared: sum=%h, required 00000000", bus.sum);
                end
            end
            if (bus.done) begin
                doneCnt++;
                checks++;
                if (bus.sum !== 32'h3333_3333) begin
                    errors++;
                    $display("[TB] FAIL held_result: sum=%h, required 33333333", bus.sum);
                end
            end
            if (n == NBYTES + 2) begin
                checks++;
                if ({bus.busy, bus.done} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL held_idle_gap: busy=%b done=%b, required 0 0", bus.busy, bus.done);
                end
            end
            if (n == NBYTES + 3) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL held_restart: busy=%b, required 1", bus.busy);
                end
            end
            bus.op_a = $urandom;
            bus.op_b = $urandom;
        end
        checks++;
        if (doneCnt !== 1) begin
            errors++;
            $display("[TB] FAIL held_done_count: got %0d pulses, required 1", doneCnt);
        end
        bus.start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.done) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int busyCnt, doneAt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 32'h0102_0304;
        bus.op_b  = 32'h0101_0101;
        bus.cin   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.sum !== 32'h0000_0005 || bus.busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_partial: sum=%h busy=%b, required 00000005 1", bus.sum, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== {2'b00, {W{1'b0}}, 2'b00}) begin
            errors++;
            $display("[TB] FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
        end
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, busyCnt, doneAt);
        checks++;
        if ({bus.sum, bus.cout, bus.overflow} !== {32'h0000_0100, 2'b00} || doneAt !== NBYTES + 1) begin
            errors++;
            $display("[TB] FAIL after_reset_result: sum=%h cout=%b ovf=%b doneAt=%0d, required 00000100 0 0 %0d",
                     bus.sum, bus.cout, bus.overflow, doneAt, NBYTES + 1);
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_subtract();
        int busyCnt, doneAt;
        do_op(32'd5, 32'd7, 1'b0, 1'b1, busyCnt, doneAt);
        checks++;
        if ({bus.sum, bus.cout} !== {32'hFFFF_FFFE, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sub_5_minus_7: sum=%h cout=%b, required fffffffe 0", bus.sum, bus.cout);
        end
        do_op(32'd7, 32'd5, 1'b0, 1'b1, busyCnt, doneAt);
        checks++;
        if ({bus.sum, bus.cout} !== {32'h0000_0002, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sub_7_minus_5: sum=%h cout=%b, required 00000002 1", bus.sum, bus.cout);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub   = 1'b0;
`endif
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_overflow();
        test_start_held();
        test_overflow();
        test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
        test_subtract();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
